// File: rtl/sd_fifo_tail_s.sv
// Read side of the "S" srdy/drdy FIFO: issues memory reads and presents words through a 2-entry prefetch buffer.
// Optional build macro SDLIB_TAIL_USAGE_EN enables the p_usage occupancy output (tied to 0 otherwise).
module sd_fifo_tail_s #(
    parameter int unsigned depth = 16,
    parameter int unsigned width = 8,
    parameter int unsigned async = 0,
    parameter int unsigned asz   = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [asz:0]     wrptr_head,
    output logic [asz:0]     rdptr_tail,
    output logic [asz-1:0]   rd_addr,
    output logic             rd_en,
    input  logic [width-1:0] rd_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    output logic [asz+1:0]   p_usage
);
    localparam int unsigned PW = asz + 1;

    logic [asz:0]       rdptr;
    logic [asz:0]       rdptr_nxt;
    logic [asz:0]       wrptr;
    logic               inflight;
    logic [1:0]         occ;
    logic [width-1:0]   buf0;
    logic [width-1:0]   buf1;
    logic               empty;
    logic               pop;
    logic [2:0]         load;

    function automatic logic [asz:0] grey2bin(input logic [asz:0] g);
        logic [asz:0] b;
        b      = g;
        for (int i = int'(PW) - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Head pointer arrives binary or grey depending on clocking mode
    generate
        if (async != 0) begin : g_wr_grey
            assign wrptr = grey2bin(wrptr_head);
        end else begin : g_wr_bin
            assign wrptr = wrptr_head;
        end
    endgenerate

    assign empty   = (rdptr == wrptr);
    assign pop     = p_srdy & p_drdy;
    assign p_srdy  = (occ != 2'd0);
    assign p_data  = buf0;
    assign rd_addr = rdptr[asz-1:0];

    // Issue a read only when the buffer is guaranteed room once the read lands
    always_comb begin
        load      = 3'(occ) + 3'(inflight) - 3'(pop);
        rd_en     = 1'b0;
        rdptr_nxt = rdptr;
        if (!empty && (load < 3'd2)) begin
            rd_en     = 1'b1;
            rdptr_nxt = rdptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdptr    <= '0;
            inflight <= 1'b0;
        end else begin
            rdptr    <= rdptr_nxt;
            inflight <= rd_en;
        end
    end

    // Two-entry FIFO-ordered output buffer; buf0 is always the oldest word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= rd_data;
                    else             buf1 <= rd_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= rd_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grey-coded pointer is registered so the head sees a glitch-free single-bit change
    generate
        if (async != 0) begin : g_rd_grey
            always_ff @(posedge clk or posedge reset) begin
                if (reset) rdptr_tail <= '0;
                else       rdptr_tail <= rdptr_nxt ^ (rdptr_nxt >> 1);
            end
        end else begin : g_rd_bin
            assign rdptr_tail = rdptr;
        end
    endgenerate

`ifdef SDLIB_TAIL_USAGE_EN
    localparam int unsigned UW = asz + 2;
    logic [asz:0] diff;
    assign diff    = wrptr - rdptr;
    assign p_usage = UW'(diff) + UW'(inflight) + UW'(occ);
`else
    assign p_usage = '0;
`endif

endmodule

// File: tb/tb_sd_fifo_tail_s.sv
// Directed bench for sd_fifo_tail_s: vector table plus sequences for burst, backpressure, wrap, reset and two-clock mode.
module tb_sd_fifo_tail_s;
`ifdef SDLIB_TAIL_USAGE_EN
    localparam bit USAGE_ON = 1'b1;
`else
    localparam bit USAGE_ON = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- single-clock instance ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] wrptr_head, rdptr_tail;
    logic [3:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       p_srdy, p_drdy;
    logic [7:0] p_data;
    logic [5:0] p_usage;

    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] mem [16];
    logic [4:0] wrptr, rdcnt;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    sd_fifo_tail_s #(.depth(16), .width(8), .async(0)) u_sync (
        .clk(clk), .reset(reset), .wrptr_head(wrptr_head), .rdptr_tail(rdptr_tail),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .p_srdy(p_srdy),
        .p_drdy(p_drdy), .p_data(p_data), .p_usage(p_usage)
    );

    assign wrptr_head = wrptr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wrptr <= '0;
            rdcnt <= '0;
        end else begin
            if (wr_en) wrptr <= wrptr + 5'd1;
            if (rd_en) rdcnt <= rdcnt + 5'd1;
        end
    end
    always @(posedge clk) begin
        if (wr_en && !reset) mem[wrptr[3:0]] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the scoreboard before the next posedge
    task automatic cycle(input bit we, input logic [7:0] d, input bit dr);
        @(negedge clk);
        wr_en = we; wr_data = d; p_drdy = dr;
        #1;
        chk("usage", 32'(p_usage), USAGE_ON ? sb.size() : 0);
        chk("occ_le_2", 32'(u_sync.occ <= 2'd2), 1);
        if (rd_en) chk("rd_en_when_empty", 32'(rdcnt != wrptr), 1);
        if (p_srdy) begin
            if (sb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL extra_word: got %0h expected none", p_data);
            end else begin
                chk("p_data", 32'(p_data), 32'(sb[0]));
                if (p_drdy) void'(sb.pop_front());
            end
        end
        if (we) sb.push_back(d);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            cycle(0, 8'h00, 1);
            k++;
        end
        chk(name, sb.size(), 0);
    endtask

    typedef struct {
        bit         we;
        logic [7:0] d;
        bit         dr;
        bit         e_rd_en;
        bit         e_srdy;
        logic [7:0] e_data;
        int         e_usage;
    } vec_t;

    // ---------------- two-clock instance ----------------
    logic       wclk = 1'b0, rclk = 1'b0;
    int         hw = 15, hr = 5;
    logic       areset;
    logic [4:0] a_wrptr_head, a_rdptr_tail;
    logic [3:0] a_rd_addr;
    logic       a_rd_en, a_srdy, a_drdy, a_wen;
    logic [7:0] a_rd_data, a_pdata, a_wd;
    logic [5:0] a_usage;
    logic [7:0] amem [16];
    logic [4:0] wbin, wgrey, ws1, ws2, rs1, rs2;
    logic [7:0] asb [$];

    always #(hw) wclk = ~wclk;
    always #(hr) rclk = ~rclk;

    sd_fifo_tail_s #(.depth(16), .width(8), .async(1)) u_async (
        .clk(rclk), .reset(areset), .wrptr_head(a_wrptr_head), .rdptr_tail(a_rdptr_tail),
        .rd_addr(a_rd_addr), .rd_en(a_rd_en), .rd_data(a_rd_data), .p_srdy(a_srdy),
        .p_drdy(a_drdy), .p_data(a_pdata), .p_usage(a_usage)
    );

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    always @(posedge wclk or posedge areset) begin
        if (areset) begin
            wbin <= '0; wgrey <= '0; rs1 <= '0; rs2 <= '0;
        end else begin
            if (a_wen) begin
                wbin  <= wbin + 5'd1;
                wgrey <= b2g(wbin + 5'd1);
            end
            rs1 <= a_rdptr_tail; rs2 <= rs1;
        end
    end
    always @(posedge wclk) if (a_wen && !areset) amem[wbin[3:0]] <= a_wd;
    always @(posedge rclk or posedge areset) begin
        if (areset) begin ws1 <= '0; ws2 <= '0; end
        else begin ws1 <= wgrey; ws2 <= ws1; end
    end
    always @(posedge rclk) if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    assign a_wrptr_head = ws2;

    task automatic async_phase(input int whalf, input int rhalf, input int nwords);
        int got = 0;
        int k   = 0;
        logic [4:0] prev;
        hw = whalf; hr = rhalf;
        prev = a_rdptr_tail;
        fork
            begin
                int sent = 0;
                int j = 0;
                while (sent < nwords && j < 4000) begin
                    @(negedge wclk);
                    a_wen = ((wbin - g2b(rs2)) != 5'd16) && ($urandom_range(0, 1) == 1);
                    a_wd  = 8'($urandom);
                    if (a_wen) begin asb.push_back(a_wd); sent++; end
                    j++;
                end
                @(negedge wclk);
                a_wen = 1'b0;
            end
            begin
                while (got < nwords && k < 4000) begin
                    @(negedge rclk);
                    a_drdy = ($urandom_range(0, 1) == 1);
                    #1;
                    if (a_rdptr_tail != prev) chk("grey_one_bit", $countones(a_rdptr_tail ^ prev), 1);
                    prev = a_rdptr_tail;
                    if (a_srdy && a_drdy) begin
                        if (asb.size() == 0) begin
                            n_vec++; n_bad++;
                            $display("FAIL async_extra: got %0h expected none", a_pdata);
                        end else begin
                            chk("async_data", 32'(a_pdata), 32'(asb.pop_front()));
                        end
                        got++;
                    end
                    k++;
                end
            end
        join
        chk("async_count", got, nwords);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t tv[6];
        tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 0};
        tv[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        tv[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1};
        tv[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1};
        tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0};
        tv[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0};

        reset = 1'b1; areset = 1'b1;
        wr_en = 1'b0; wr_data = '0; p_drdy = 1'b0;
        a_wen = 1'b0; a_wd = '0; a_drdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_srdy", 32'(p_srdy), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rdptr_tail", 32'(rdptr_tail), 0);
        chk("rst_usage", 32'(p_usage), 0);
        chk("rst_p_data", 32'(p_data), 0);
        reset = 1'b0;

        // Single word latency
        foreach (tv[i]) begin
            cycle(tv[i].we, tv[i].d, tv[i].dr);
            chk("tv_rd_en", 32'(rd_en), 32'(tv[i].e_rd_en));
            chk("tv_srdy", 32'(p_srdy), 32'(tv[i].e_srdy));
            if (tv[i].e_srdy) chk("tv_data", 32'(p_data), 32'(tv[i].e_data));
            chk("tv_usage", 32'(p_usage), USAGE_ON ? tv[i].e_usage : 0);
        end

        // Back-to-back burst: 16 words pop on 16 consecutive cycles starting 3 after the first write
        for (int c = 0; c < 20; c++) begin
            cycle(c < 16, 8'(c), 1);
            chk("burst_srdy", 32'(p_srdy), 32'(c >= 3 && c <= 18));
        end
        drain("burst_drained");

        // Backpressure: queue 16 words, stall, then release
        for (int c = 0; c < 16; c++) cycle(1, 8'(8'h40 + c * 3), 0);
        for (int c = 0; c < 10; c++) begin
            cycle(0, 8'h00, 0);
            chk("bp_rd_en", 32'(rd_en), 0);
            chk("bp_srdy", 32'(p_srdy), 1);
            chk("bp_occ", 32'(u_sync.occ), 2);
            chk("bp_usage", 32'(p_usage), USAGE_ON ? 16 : 0);
        end
        drain("bp_drained");

        // Wrap with random backpressure, starting from a full FIFO
        begin
            int nw = 0;
            int k  = 0;
            for (int c = 0; c < 16; c++) begin cycle(1, 8'(8'h80 + c), 0); nw++; end
            cycle(0, 8'h00, 0);
            chk("full_usage", 32'(p_usage), USAGE_ON ? 16 : 0);
            while (nw < 40 && k < 400) begin
                bit we;
                we = (sb.size() < 16) && ($urandom_range(0, 3) != 0);
                cycle(we, 8'(8'h80 + nw), $urandom_range(0, 1) == 1);
                if (we) nw++;
                k++;
            end
            chk("wrap_writes", nw, 40);
            drain("wrap_drained");
        end

        // Asynchronous reset mid-stream with a read in flight
        for (int c = 0; c < 6; c++) cycle(1, 8'(8'h10 + c), c[0]);
        @(negedge clk);
        wr_en = 1'b0;
        chk("pre_rst_inflight", 32'(u_sync.inflight), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_srdy", 32'(p_srdy), 0);
        chk("arst_rdptr_tail", 32'(rdptr_tail), 0);
        chk("arst_usage", 32'(p_usage), 0);
        chk("arst_rd_en", 32'(rd_en), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 8'h3C, 1);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        chk("post_rst_srdy", 32'(p_srdy), 1);
        chk("post_rst_data", 32'(p_data), 32'h3C);
        drain("post_rst_drained");

        // Two-clock mode at 1:3 and 3:1 ratios
        areset = 1'b0;
        async_phase(15, 5, 100);
        async_phase(5, 15, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_fifo_tail_s.md
# sd_fifo_tail_s

Read-side half of the "S" srdy/drdy FIFO: pairs with the FIFO head over a shared power-of-2 memory with one-cycle read latency, issues memory reads, and presents words on a producer-side srdy/drdy interface. It tracks the read pointer against the head's write pointer, prefetches into a 2-entry output buffer so `p_drdy` stalls never lose data, and supports two-clock operation via grey-coded pointer exchange.

## Interface
- `depth`, 16: FIFO size in words; power of 2, ≥4.
- `width`, 8: data word width.
- `async`, 0: 1 = two-clock FIFO (grey-coded pointers), 0 = single-clock (binary pointers).
- `asz`, $clog2(depth): address size, derived; not overridden.
- `clk`  in  1  read-side clock.
- `reset`  in  1  asynchronous, active-high.
- `wrptr_head`  in  asz+1  write pointer from head; binary if async=0, grey (already synchronized into clk) if async=1.
- `rdptr_tail`  out  asz+1  read pointer to head; binary if async=0, grey if async=1.
- `rd_addr`  out  asz  memory read address (rdptr[asz-1:0]).
- `rd_en`  out  1  memory read strobe.
- `rd_data`  in  width  memory data, valid the cycle after `rd_en`.
- `p_srdy`  out  1  output word valid.
- `p_drdy`  in  1  downstream ready.
- `p_data`  out  width  output word.
- `p_usage`  out  asz+2  words held: memory + in flight + output buffer.

## Operation
- Internal binary `rdptr[asz:0]`; `wrptr` = `wrptr_head` (async=0) or grey2bin(`wrptr_head`) (async=1).
- empty = (rdptr == wrptr), all asz+1 bits.
- `inflight`: register = `rd_en` of previous cycle. `occ`: output-buffer count, 0..2.
- pop = `p_srdy & p_drdy`.
- `rd_en` = !empty & (occ + inflight − pop < 2); combinational. On `rd_en`, rdptr ← rdptr+1, wrapping mod 2^(asz+1).
- On inflight=1, `rd_data` is written into the buffer at the clock edge ending that cycle.
- Buffer is FIFO-ordered: `p_data` = oldest entry; `p_srdy` = (occ != 0). Simultaneous capture and pop in one cycle: pop oldest, append new; occ unchanged.
- Overflow is impossible by the `rd_en` rule; the bench asserts occ ≤ 2.
- async=0: `rdptr_tail` = rdptr, combinational alias. async=1: `rdptr_tail` is a register loaded with bin2grey(next rdptr), so exactly one bit toggles per increment.
- `p_usage` = (wrptr − rdptr, mod 2^(asz+1)) + inflight + occ; max depth+... bounded by depth.
- Reset (any time, asynchronous): rdptr=0, `rdptr_tail`=0, inflight=0, occ=0, `p_data`=0, `p_srdy`=0, `rd_en`=0 (empty), `p_usage`=0. In-flight and buffered data are discarded. The head must be reset in the same interval; mid-operation reset with the head not reset is unsupported.

## Timing
- Single-clock write-to-read latency: head `wr_en` in cycle 0 → `wrptr_head` updates cycle 1 → `rd_en` cycle 1 → `rd_data` cycle 2 → `p_srdy` cycle 3.
- Read latency: `rd_en` cycle T → word on `p_data`/`p_srdy` in cycle T+2.
- Throughput: with `p_drdy`=1 and FIFO non-empty, one word per cycle sustained, no bubbles.
- `p_drdy` may change arbitrarily; `p_srdy`/`p_data` hold stable until popped.
- async=1: `rdptr_tail` reflects a read one cycle after `rd_en`. The empty flag lags a write by the head's register plus the external synchronizer; this lag is safe (conservative).
- Full FIFO (wrptr − rdptr = depth): reads proceed normally. The MSB difference is resolved by the modular subtract.

## Configuration
- `SDLIB_TAIL_USAGE_EN` defined: `p_usage` is computed as above.
- `SDLIB_TAIL_USAGE_EN` not defined: `p_usage` is tied to 0 and the usage adder is not built. All other behaviour is identical.

## Test plan
- Single word, async=0, depth=16: head writes 0xA5 at cycle 0 → `rd_en` at 1, `p_srdy`=1 with `p_data`=0xA5 at 3; pop → `p_srdy`=0, `p_usage`=0.
- Burst: write 0..15 back-to-back with `p_drdy`=1 → outputs 0..15 on 16 consecutive cycles; `rd_en` never high when empty.
- Backpressure: 16 words queued, `p_drdy`=0 for 10 cycles → occ=2, `rd_en` low, `p_usage`=16, `p_data` stable. Release → remaining words in order, none lost or duplicated.
- Wrap: 40 writes/reads with random `p_drdy` → data in order; rdptr passes 31→0; full condition (usage 16) is reached and drained.
- async=1, clk ratios 1:3 and 3:1, 200 random words → in-order data; each `rdptr_tail` change differs in exactly one bit.
- Reset with occ=2 and inflight=1 → next cycle `p_srdy`=0, `rdptr_tail`=0, `p_usage`=0; post-reset write of 0x3C is read correctly.
